// File: rtl/m64282_sensor_emu.sv
// -----------------------------------------------------------------------------
// m64282_sensor_emu
//
// Responder-side model of the M64282FP image sensor. It listens on the sens_*
// pins driven by the camera cart logic, holds the eight 8-bit sensor registers
// loaded through the serial port, runs an exposure of programmable length and
// then streams a deterministic test pattern so captured frames are bit-checkable.
//
// Ports
//   sys_clock   in   system clock, sole clock of the block
//   resetn      in   asynchronous active-low reset
//   sens_xck    in   sensor clock (asynchronous, at most sys_clock/8)
//   sens_reset  in   sensor reset, active low, acts on its synchronized level
//   sens_sin    in   serial register data, MSB first
//   sens_load   in   register latch strobe, high with the last serial bit
//   sens_start  in   exposure start, sampled on XCK rise
//   sens_read   out  high while the frame is being read out
//   pix_data    out  current pixel value
//   pix_valid   out  one-sys_clock pulse per pixel
//   busy        out  high while exposing or reading out
//   dbg_addr    in   register readback select
//   dbg_data    out  reg[dbg_addr], combinational
// -----------------------------------------------------------------------------
module m64282_sensor_emu #(
    parameter int WIDTH       = 128,
    parameter int HEIGHT      = 128,
    parameter int EXP_UNIT    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       sys_clock,
    input  logic       resetn,
    input  logic       sens_xck,
    input  logic       sens_reset,
    input  logic       sens_sin,
    input  logic       sens_load,
    input  logic       sens_start,
    output logic       sens_read,
    output logic [7:0] pix_data,
    output logic       pix_valid,
    output logic       busy,
    input  logic [2:0] dbg_addr,
    output logic [7:0] dbg_data
);

    // Counters are at least 7 bits wide because the pattern always uses x[6:0], y[6:0].
    localparam int XW = ($clog2(WIDTH)  < 7) ? 7 : $clog2(WIDTH);
    localparam int YW = ($clog2(HEIGHT) < 7) ? 7 : $clog2(HEIGHT);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXPOSE  = 2'd1;
    localparam logic [1:0] ST_READOUT = 2'd2;

    // ---------------------------------------------------------------------
    // Input synchronizers. Bit order in each stage: {reset, start, load, sin, xck}.
    // ---------------------------------------------------------------------
    logic [4:0] sync_q [SYNC_STAGES];
    logic       xck_prev_q;
    logic       xck_s, sin_s, load_s, start_s, srst;
    logic       xck_rise, xck_fall;

    assign xck_s    = sync_q[SYNC_STAGES-1][0];
    assign sin_s    = sync_q[SYNC_STAGES-1][1];
    assign load_s   = sync_q[SYNC_STAGES-1][2];
    assign start_s  = sync_q[SYNC_STAGES-1][3];
    assign srst     = ~sync_q[SYNC_STAGES-1][4];
    assign xck_rise = xck_s & ~xck_prev_q;
    assign xck_fall = ~xck_s & xck_prev_q;

    // The synchronizers only see resetn; a sensor reset must not stall edge detection.
    always_ff @(posedge sys_clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            xck_prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the old value of
            // its predecessor, which is what turns this loop into a shift chain.
            sync_q[0] <= {sens_reset, sens_start, sens_load, sens_sin, sens_xck};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            xck_prev_q <= xck_s;
        end
    end

    // ---------------------------------------------------------------------
    // Serial register port. Only the low 10 bits of the shifter are kept: the
    // eleventh bit of a word is the incoming sin itself.
    // ---------------------------------------------------------------------
    logic [7:0]  regs_q [8];
    logic [7:0]  regs_d [8];
    logic [9:0]  shift_q, shift_d;
    logic [10:0] ser_word;

    assign ser_word = {shift_q, sin_s};

    always_comb begin
        // NOTE: every variable gets a default before any condition so this block
        // stays purely combinational instead of inferring latches.
        regs_d  = regs_q;
        shift_d = shift_q;
        if (xck_rise) begin
            shift_d = ser_word[9:0];
            if (load_s) regs_d[ser_word[10:8]] = ser_word[7:0];
        end
        if (srst) begin
            regs_d  = '{default: '0};
            shift_d = '0;
        end
    end

    // Exposure length taken from the post-write register view, so a LOAD and a
    // START in the same sample start with the freshly written count.
    logic [15:0] c_word;
    logic [19:0] c_eff, exp_len;

    assign c_word  = {regs_d[2], regs_d[3]};
    assign c_eff   = (c_word == 16'd0) ? 20'd1 : {4'd0, c_word};
    assign exp_len = c_eff * 20'(EXP_UNIT);

    // ---------------------------------------------------------------------
    // Exposure / readout state machine
    // ---------------------------------------------------------------------
    logic [1:0]    state_q, state_d;
    logic [19:0]   exp_cnt_q, exp_cnt_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [7:0]    pix_data_q, pix_data_d, base;
    logic          pix_valid_q, pix_valid_d;

    // Sum of two 7-bit values never exceeds 254, so 8 bits hold it exactly.
    assign base = 8'(x_q[6:0]) + 8'(y_q[6:0]);

    always_comb begin
        state_d     = state_q;
        exp_cnt_d   = exp_cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        pix_data_d  = pix_data_q;
        pix_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (xck_rise && start_s) begin
                    exp_cnt_d = exp_len;
                    state_d   = ST_EXPOSE;
                end
            end
            ST_EXPOSE: begin
                if (xck_rise) begin
                    exp_cnt_d = exp_cnt_q - 20'd1;
                    if (exp_cnt_d == 20'd0) begin
                        state_d = ST_READOUT;
                        x_d     = '0;
                        y_d     = '0;
                    end
                end
            end
            ST_READOUT: begin
                if (xck_fall) begin
                    // reg[0] is read live: an inversion change hits the next pixel.
                    pix_data_d  = regs_q[0][7] ? ~base : base;
                    pix_valid_d = 1'b1;
                    if (x_q == XW'(WIDTH - 1)) begin
                        x_d = '0;
                        if (y_q == YW'(HEIGHT - 1)) begin
                            y_d     = '0;
                            state_d = ST_IDLE;
                        end else begin
                            y_d = y_q + YW'(1);
                        end
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (srst) begin
            state_d     = ST_IDLE;
            exp_cnt_d   = '0;
            x_d         = '0;
            y_d         = '0;
            pix_data_d  = '0;
            pix_valid_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clock or negedge resetn) begin
        if (!resetn) begin
            // NOTE: the register file is eight flops-wide words, not a RAM, so it is
            // reset like any other state and reads back 0 straight out of reset.
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
            shift_q     <= '0;
            state_q     <= ST_IDLE;
            exp_cnt_q   <= '0;
            x_q         <= '0;
            y_q         <= '0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
            shift_q     <= shift_d;
            state_q     <= state_d;
            exp_cnt_q   <= exp_cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
        end
    end

    assign sens_read = (state_q == ST_READOUT);
    assign busy      = (state_q != ST_IDLE);
    assign pix_data  = pix_data_q;
    assign pix_valid = pix_valid_q;
    assign dbg_data  = regs_q[dbg_addr];

endmodule

// File: tb/tb_m64282_sensor_emu.sv
// -----------------------------------------------------------------------------
// tb_m64282_sensor_emu
//
// Drives the sens_* pins like the cart logic would (XCK = sys_clock/8) and
// compares everything against a register/pattern model kept in the bench.
// The frame is shortened to 128 x 6 so several complete frames fit in a run.
// -----------------------------------------------------------------------------
module tb_m64282_sensor_emu;

    localparam int W    = 128;
    localparam int H    = 6;
    localparam int NPIX = W * H;
    localparam int EU   = 8;

    logic       sys_clock = 1'b0;
    logic       resetn;
    logic       sens_xck, sens_reset, sens_sin, sens_load, sens_start;
    logic       sens_read, pix_valid, busy;
    logic [7:0] pix_data, dbg_data;
    logic [2:0] dbg_addr;

    m64282_sensor_emu #(
        .WIDTH(W), .HEIGHT(H), .EXP_UNIT(EU), .SYNC_STAGES(2)
    ) dut (
        .sys_clock (sys_clock),
        .resetn    (resetn),
        .sens_xck  (sens_xck),
        .sens_reset(sens_reset),
        .sens_sin  (sens_sin),
        .sens_load (sens_load),
        .sens_start(sens_start),
        .sens_read (sens_read),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .busy      (busy),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    initial forever #5 sys_clock = ~sys_clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] mregs [8];

    function automatic int exp_rises();
        int c;
        c = {mregs[2], mregs[3]};
        if (c == 0) c = 1;
        return c * EU;
    endfunction

    function automatic logic [7:0] exp_pix(input int idx, input logic [7:0] r0);
        int x, y, s;
        logic [7:0] b;
        x = idx % W;
        y = idx / W;
        s = (x % 128) + (y % 128);
        b = s[7:0];
        return r0[7] ? ~b : b;
    endfunction

    // ---------------- output monitor ----------------
    int         pix_cnt    = 0;
    int         frame_base = 0;
    int         busy_falls = 0;
    logic       busy_prev  = 1'b0;
    logic [7:0] cap [NPIX];
    int         mon_idx;

    always @(negedge sys_clock) begin
        if (pix_valid === 1'b1) begin
            mon_idx = pix_cnt - frame_base;
            if (mon_idx >= 0 && mon_idx < NPIX) cap[mon_idx] = pix_data;
            pix_cnt++;
        end
        if (busy_prev && busy === 1'b0) busy_falls++;
        busy_prev = (busy === 1'b1);
    end

    // ---------------- pin-level driver ----------------
    logic last_read;

    // One XCK period: inputs settle during the low phase, rise, sample sens_read
    // late in the high phase, fall.
    task automatic xck_cycle(input logic sin, input logic ld, input logic st);
        sens_sin   = sin;
        sens_load  = ld;
        sens_start = st;
        #40 sens_xck = 1'b1;
        #36 last_read = sens_read;
        #4  sens_xck = 1'b0;
    endtask

    task automatic write_reg(input logic [2:0] addr, input logic [7:0] data, input logic st_last);
        logic [10:0] word;
        word = {addr, data};
        for (int i = 10; i >= 0; i--) xck_cycle(word[i], (i == 0), st_last && (i == 0));
        sens_load  = 1'b0;
        sens_start = 1'b0;
        mregs[addr] = data;
    endtask

    task automatic check_regs(input string tag);
        for (int a = 0; a < 8; a++) begin
            dbg_addr = 3'(a);
            #5 check(tag, dbg_data, mregs[a]);
            #5;
        end
    endtask

    // Counts XCK rises after the START rise until sens_read is seen high.
    task automatic do_exposure(input int ign_at, output int rises);
        rises = -1;
        for (int k = 1; k <= 4000; k++) begin
            xck_cycle(1'b0, 1'b0, (k == ign_at));
            if (last_read) begin
                rises = k;
                break;
            end
        end
    endtask

    // Enough falls for a whole frame plus a few idle ones afterwards.
    task automatic do_readout(input int ign_at);
        logic done, st;
        done = 1'b0;
        for (int c = 0; c < NPIX + 4; c++) begin
            st = !done && (ign_at >= 0) && ((pix_cnt - frame_base) >= ign_at);
            if (st) done = 1'b1;
            xck_cycle(1'b0, 1'b0, st);
        end
    endtask

    task automatic frame_checks(input string tag, input logic [7:0] r0);
        int bad, ri;
        bad = 0;
        for (int i = 0; i < NPIX; i++) if (cap[i] !== exp_pix(i, r0)) bad++;
        check({tag, "_pix_count"}, pix_cnt - frame_base, NPIX);
        check({tag, "_bad_pixels"}, bad, 0);
        ri = $urandom_range(NPIX - 1, 0);
        check({tag, "_rand_pixel"}, cap[ri], exp_pix(ri, r0));
        check({tag, "_read_after"}, sens_read, 1'b0);
        check({tag, "_busy_after"}, busy, 1'b0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    int rises, falls0, cnt0;
    logic [7:0] cval;

    initial begin
        resetn = 1'b0; sens_xck = 1'b0; sens_reset = 1'b1;
        sens_sin = 1'b0; sens_load = 1'b0; sens_start = 1'b0;
        dbg_addr = 3'd0; last_read = 1'b0;
        for (int a = 0; a < 8; a++) mregs[a] = 8'h00;
        #2;  // keep all pin changes 2 ns past a multiple of 10, away from clock edges
        #50;
        check("rst_sens_read", sens_read, 1'b0);
        check("rst_pix_valid", pix_valid, 1'b0);
        check("rst_pix_data", pix_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        resetn = 1'b1;
        #100;
        check_regs("rst_reg");

        // Register write path
        write_reg(3'd2, 8'h00, 1'b0);
        write_reg(3'd3, 8'h02, 1'b0);
        check_regs("wr_reg");
        for (int i = 0; i < 4; i++) write_reg(3'(4 + i), 8'($urandom), 1'b0);
        write_reg(3'd1, 8'($urandom), 1'b0);
        check_regs("wr_rand_reg");

        // Frame A: C=2 -> 16 rises, plain pattern
        frame_base = pix_cnt;
        falls0 = busy_falls;
        xck_cycle(1'b0, 1'b0, 1'b1);
        check("A_busy_expose", busy, 1'b1);
        do_exposure(-1, rises);
        check("A_exposure_rises", rises, exp_rises());
        do_readout(-1);
        frame_checks("A", mregs[0]);
        check("A_pix_0_0", cap[0], 8'h00);
        check("A_pix_5_3", cap[3 * W + 5], 8'h08);
        check("A_pix_last", cap[NPIX - 1], 8'h84);
        check("A_idle_once", busy_falls - falls0, 1);

        // Frame B: inverted pattern
        write_reg(3'd0, 8'h80, 1'b0);
        frame_base = pix_cnt;
        xck_cycle(1'b0, 1'b0, 1'b1);
        do_exposure(-1, rises);
        check("B_exposure_rises", rises, exp_rises());
        do_readout(-1);
        frame_checks("B", mregs[0]);
        check("B_pix_0_0", cap[0], 8'hFF);
        check("B_pix_last", cap[NPIX - 1], 8'h7B);
        write_reg(3'd0, 8'h00, 1'b0);

        // Frame C: LOAD+START in one sample, extra STARTs while busy are ignored
        cval = 8'($urandom_range(6, 3));
        frame_base = pix_cnt;
        falls0 = busy_falls;
        write_reg(3'd3, cval, 1'b1);
        do_exposure($urandom_range(10, 2), rises);
        check("C_exposure_rises", rises, exp_rises());
        do_readout($urandom_range(NPIX - 50, 10));
        frame_checks("C", mregs[0]);
        check("C_idle_once", busy_falls - falls0, 1);

        // Abort with sensor reset at pixel 500
        frame_base = pix_cnt;
        xck_cycle(1'b0, 1'b0, 1'b1);
        do_exposure(-1, rises);
        check("D_exposure_rises", rises, exp_rises());
        for (int c = 0; c < NPIX; c++) begin
            if (pix_cnt - frame_base >= 500) break;
            xck_cycle(1'b0, 1'b0, 1'b0);
        end
        check("D_reached_500", pix_cnt - frame_base, 500);
        sens_reset = 1'b0;
        #20 cnt0 = pix_cnt;
        repeat (4) xck_cycle(1'b0, 1'b0, 1'b0);
        check("D_read_abort", sens_read, 1'b0);
        check("D_busy_abort", busy, 1'b0);
        check("D_pix_stopped", pix_cnt, cnt0);
        for (int a = 0; a < 8; a++) mregs[a] = 8'h00;
        check_regs("D_reg_cleared");
        sens_reset = 1'b1;
        xck_cycle(1'b0, 1'b0, 1'b0);

        // Fresh frame after abort: C=0 counts as 1 -> EXP_UNIT rises
        frame_base = pix_cnt;
        xck_cycle(1'b0, 1'b0, 1'b1);
        do_exposure(-1, rises);
        check("E_exposure_rises_c0", rises, EU);
        do_readout(-1);
        frame_checks("E", mregs[0]);
        check("E_pix_0_0", cap[0], 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
